// File: rtl/mcu_link_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : mcu_link_dispatcher
// Purpose  : Parses framed UART commands, dispatches them to one of NUM_CH
//            service channels, muxes the owning channel onto the UART
//            transmitter and arbitrates channel auto-uploads round-robin.
//            Define MCU_FRAME_CHKSUM_EN to require a trailing checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_link_dispatcher #(
    parameter int         NUM_CH         = 4,
    parameter logic [7:0] HDR_BYTE       = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 100_000_000,
    parameter int         GAP_CYCLES     = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ok,
    input  logic                  tx_idle,
    output logic [7:0]            tx_data,
    output logic                  start_tx,
    output logic [NUM_CH-1:0]     ch_start,
    output logic [7:0]            ch_ctrl_code,
    output logic [7:0]            ch_pl_data,
    output logic [NUM_CH-1:0]     ch_pl_valid,
    input  logic [NUM_CH-1:0]     ch_auto_req,
    output logic [NUM_CH-1:0]     ch_grant,
    input  logic [8*NUM_CH-1:0]   ch_tx_data,
    input  logic [NUM_CH-1:0]     ch_start_tx,
    input  logic [NUM_CH-1:0]     ch_done,
    output logic                  frame_err,
    output logic                  timeout_err,
    output logic                  link_busy
);

    localparam int c_TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_GPW = $clog2(GAP_CYCLES + 1);
    localparam logic [c_TOW-1:0] c_TO_LAST  = c_TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_GPW-1:0] c_GAP_LAST = c_GPW'(GAP_CYCLES - 1);
    localparam logic [4:0]       c_NCH      = 5'(NUM_CH);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_CODE     = 3'd1;
    localparam logic [2:0] c_ST_LEN      = 3'd2;
    localparam logic [2:0] c_ST_PAYLOAD  = 3'd3;
    localparam logic [2:0] c_ST_DISPATCH = 3'd5;
    localparam logic [2:0] c_ST_AUTO     = 3'd6;
`ifdef MCU_FRAME_CHKSUM_EN
    localparam logic [2:0] c_ST_CHK      = 3'd4;
    localparam logic [2:0] c_ST_BODY_END = c_ST_CHK;
`else
    localparam logic [2:0] c_ST_BODY_END = c_ST_DISPATCH;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [3:0]        r_chan;
    logic [7:0]        r_len;
    logic [7:0]        r_pl_cnt;
    logic [3:0]        r_rr_ptr;
    logic [c_TOW-1:0]  r_to_cnt;
    logic [c_GPW-1:0]  r_gap_cnt;
`ifdef MCU_FRAME_CHKSUM_EN
    logic [7:0]        r_sum;
`endif

    logic              w_in_frame;
    logic              w_gap_expired;
    logic              w_to_expired;
    logic              w_owned;
    logic              w_done;
    logic              w_code_ok;
    logic              w_disp_go;
    logic              w_auto_go;
    logic              w_ferr;
    logic              w_terr;
    logic              w_release;
    logic [NUM_CH-1:0] w_chan_oh;
    logic [NUM_CH-1:0] w_rr_oh;
    logic              w_rr_found;
    logic [3:0]        w_rr_idx;
    logic [4:0]        w_rr_sum;
    logic [4:0]        w_rr_inc;
    logic [3:0]        w_rr_next;

    assign w_in_frame    = (r_state == c_ST_CODE) || (r_state == c_ST_LEN) ||
`ifdef MCU_FRAME_CHKSUM_EN
                           (r_state == c_ST_CHK) ||
`endif
                           (r_state == c_ST_PAYLOAD);
    assign w_gap_expired = w_in_frame && !rx_ok && (r_gap_cnt == c_GAP_LAST);
    assign w_owned       = (r_state == c_ST_DISPATCH) || (r_state == c_ST_AUTO);
    assign w_to_expired  = w_owned && (r_to_cnt == c_TO_LAST);
    assign w_done        = w_owned && |(ch_done & ch_grant);
    assign w_code_ok     = {1'b0, rx_data[7:4]} < c_NCH;
    assign w_disp_go     = (w_next == c_ST_DISPATCH) && (r_state != c_ST_DISPATCH);
    assign link_busy     = (r_state != c_ST_IDLE);

    always_comb begin
        w_chan_oh = '0;
        w_rr_oh   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_chan_oh[i] = (r_chan == 4'(i));
            w_rr_oh[i]   = (w_rr_idx == 4'(i));
        end
    end

    // Scan offsets high-to-low so the closest requester at/after the pointer wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_rr_sum   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_rr_sum = {1'b0, r_rr_ptr} + 5'(i);
            if (w_rr_sum >= c_NCH) begin
                w_rr_sum = w_rr_sum - c_NCH;
            end
            for (int j = 0; j < NUM_CH; j++) begin
                if ((w_rr_sum == 5'(j)) && ch_auto_req[j]) begin
                    w_rr_found = 1'b1;
                    w_rr_idx   = 4'(j);
                end
            end
        end
    end

    assign w_rr_inc  = {1'b0, w_rr_idx} + 5'd1;
    assign w_rr_next = (w_rr_inc >= c_NCH) ? 4'd0 : w_rr_inc[3:0];

    always_comb begin
        tx_data  = '0;
        start_tx = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_grant[i]) begin
                tx_data  = ch_tx_data[8*i +: 8];
                start_tx = ch_start_tx[i];
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_auto_go = 1'b0;
        w_ferr    = 1'b0;
        w_terr    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (rx_ok && (rx_data == HDR_BYTE)) begin
                    w_next = c_ST_CODE;
                end else if (w_rr_found) begin
                    w_next    = c_ST_AUTO;
                    w_auto_go = 1'b1;
                end
            end
            c_ST_CODE: begin
                if (w_gap_expired || (rx_ok && !w_code_ok)) begin
                    w_ferr = 1'b1;
                    w_next = c_ST_IDLE;
                end else if (rx_ok) begin
                    w_next = c_ST_LEN;
                end
            end
            c_ST_LEN: begin
                if (w_gap_expired) begin
                    w_ferr = 1'b1;
                    w_next = c_ST_IDLE;
                end else if (rx_ok) begin
                    w_next = (rx_data == 8'd0) ? c_ST_BODY_END : c_ST_PAYLOAD;
                end
            end
            c_ST_PAYLOAD: begin
                if (w_gap_expired) begin
                    w_ferr = 1'b1;
                    w_next = c_ST_IDLE;
                end else if (rx_ok && (r_pl_cnt == r_len - 8'd1)) begin
                    w_next = c_ST_BODY_END;
                end
            end
`ifdef MCU_FRAME_CHKSUM_EN
            c_ST_CHK: begin
                if (w_gap_expired || (rx_ok && (rx_data != r_sum))) begin
                    w_ferr = 1'b1;
                    w_next = c_ST_IDLE;
                end else if (rx_ok) begin
                    w_next = c_ST_DISPATCH;
                end
            end
`endif
            c_ST_DISPATCH, c_ST_AUTO: begin
                // Done wins over a coincident timeout; timeout waits for an idle transmitter.
                if (w_done) begin
                    w_release = 1'b1;
                    w_next    = c_ST_IDLE;
                end else if (w_to_expired && tx_idle) begin
                    w_terr    = 1'b1;
                    w_release = 1'b1;
                    w_next    = c_ST_IDLE;
                end
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_chan       <= '0;
            r_len        <= '0;
            r_pl_cnt     <= '0;
            r_rr_ptr     <= '0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
`ifdef MCU_FRAME_CHKSUM_EN
            r_sum        <= '0;
`endif
            ch_start     <= '0;
            ch_ctrl_code <= '0;
            ch_pl_data   <= '0;
            ch_pl_valid  <= '0;
            ch_grant     <= '0;
            frame_err    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            r_state     <= w_next;
            ch_start    <= '0;
            ch_pl_valid <= '0;
            frame_err   <= w_ferr;
            timeout_err <= w_terr;

            if (!w_in_frame || rx_ok) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != c_GAP_LAST) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end

            if (rx_ok) begin
                case (r_state)
                    c_ST_CODE: begin
                        ch_ctrl_code <= rx_data;
                        r_chan       <= rx_data[7:4];
`ifdef MCU_FRAME_CHKSUM_EN
                        r_sum        <= rx_data;
`endif
                    end
                    c_ST_LEN: begin
                        r_len    <= rx_data;
                        r_pl_cnt <= '0;
`ifdef MCU_FRAME_CHKSUM_EN
                        r_sum    <= r_sum + rx_data;
`endif
                    end
                    c_ST_PAYLOAD: begin
                        ch_pl_data  <= rx_data;
                        ch_pl_valid <= w_chan_oh;
                        r_pl_cnt    <= r_pl_cnt + 8'd1;
`ifdef MCU_FRAME_CHKSUM_EN
                        r_sum       <= r_sum + rx_data;
`endif
                    end
                    default: ;
                endcase
            end

            if (w_disp_go || w_auto_go) begin
                r_to_cnt <= '0;
            end else if (w_owned && !w_to_expired) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_disp_go) begin
                ch_grant <= w_chan_oh;
                ch_start <= w_chan_oh;
            end else if (w_auto_go) begin
                ch_grant <= w_rr_oh;
                r_rr_ptr <= w_rr_next;
            end else if (w_release) begin
                ch_grant <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcu_link_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_link_dispatcher
// Purpose  : Directed self-checking bench for mcu_link_dispatcher (NUM_CH=4,
//            short timeout/gap limits); checksum bytes sent only when
//            MCU_FRAME_CHKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_link_dispatcher;

    localparam int c_NUM_CH  = 4;
    localparam int c_TIMEOUT = 1000;
    localparam int c_GAP     = 50;

    logic                    clk;
    logic                    rst;
    logic [7:0]              rx_data;
    logic                    rx_ok;
    logic                    tx_idle;
    logic [7:0]              tx_data;
    logic                    start_tx;
    logic [c_NUM_CH-1:0]     ch_start;
    logic [7:0]              ch_ctrl_code;
    logic [7:0]              ch_pl_data;
    logic [c_NUM_CH-1:0]     ch_pl_valid;
    logic [c_NUM_CH-1:0]     ch_auto_req;
    logic [c_NUM_CH-1:0]     ch_grant;
    logic [8*c_NUM_CH-1:0]   ch_tx_data;
    logic [c_NUM_CH-1:0]     ch_start_tx;
    logic [c_NUM_CH-1:0]     ch_done;
    logic                    frame_err;
    logic                    timeout_err;
    logic                    link_busy;

    int n_vec = 0;
    int n_err = 0;

    mcu_link_dispatcher #(
        .NUM_CH         (c_NUM_CH),
        .HDR_BYTE       (8'hAA),
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .GAP_CYCLES     (c_GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_ok        (rx_ok),
        .tx_idle      (tx_idle),
        .tx_data      (tx_data),
        .start_tx     (start_tx),
        .ch_start     (ch_start),
        .ch_ctrl_code (ch_ctrl_code),
        .ch_pl_data   (ch_pl_data),
        .ch_pl_valid  (ch_pl_valid),
        .ch_auto_req  (ch_auto_req),
        .ch_grant     (ch_grant),
        .ch_tx_data   (ch_tx_data),
        .ch_start_tx  (ch_start_tx),
        .ch_done      (ch_done),
        .frame_err    (frame_err),
        .timeout_err  (timeout_err),
        .link_busy    (link_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_ok   = 1'b1;
        tick();
        rx_ok   = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_chk(input logic [7:0] b);
`ifdef MCU_FRAME_CHKSUM_EN
        send(b);
`else
        b = b;
`endif
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int  n;
        bit  seen;

        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_ok       = 1'b0;
        tx_idle     = 1'b1;
        ch_auto_req = '0;
        ch_tx_data  = '0;
        ch_start_tx = '0;
        ch_done     = '0;
        tick(); tick(); tick();

        check("rst_grant",     ch_grant,    32'h0);
        check("rst_busy",      link_busy,   32'h0);
        check("rst_tx_data",   tx_data,     32'h0);
        check("rst_start_tx",  start_tx,    32'h0);
        check("rst_frame_err", frame_err,   32'h0);
        check("rst_pl_valid",  ch_pl_valid, 32'h0);
        rst = 1'b0;
        tick();

        // Frame AA 21 02 11 22 [56] to channel 2
        send(8'hAA);
        check("hdr_busy", link_busy, 32'h1);
        send(8'h21);
        send(8'h02);
        send(8'h11);
        check("pl0_valid", ch_pl_valid, 32'h4);
        check("pl0_data",  ch_pl_data,  32'h11);
        send(8'h22);
        check("pl1_valid", ch_pl_valid, 32'h4);
        check("pl1_data",  ch_pl_data,  32'h22);
        send_chk(8'h56);
        check("disp_start", ch_start,     32'h4);
        check("disp_grant", ch_grant,     32'h4);
        check("disp_code",  ch_ctrl_code, 32'h21);
        tick();
        check("start_pulse_one", ch_start, 32'h0);
        check("grant_hold",      ch_grant, 32'h4);

        for (int k = 0; k < 3; k++) begin
            ch_tx_data[23:16] = 8'hC0 + 8'(k);
            ch_tx_data[15:8]  = 8'h5A;
            ch_start_tx       = 4'b0110;
            #1;
            check("mux_start", start_tx, 32'h1);
            check("mux_data",  tx_data,  32'hC0 + k);
            tick();
            ch_start_tx = 4'b0010;
            #1;
            check("mux_nostart", start_tx, 32'h0);
            tick();
        end
        ch_start_tx = '0;

        ch_done = 4'b0010;
        tick();
        ch_done = '0;
        check("foreign_done_ignored", ch_grant, 32'h4);
        ch_done = 4'b0100;
        tick();
        ch_done = '0;
        check("done_grant", ch_grant,  32'h0);
        check("done_busy",  link_busy, 32'h0);
        check("done_tx",    tx_data,   32'h0);
        ch_tx_data = '0;

`ifdef MCU_FRAME_CHKSUM_EN
        send(8'hAA); send(8'h21); send(8'h01); send(8'h33); send(8'h00);
        check("badchk_ferr",  frame_err, 32'h1);
        check("badchk_start", ch_start,  32'h0);
        check("badchk_grant", ch_grant,  32'h0);
        tick();
        check("badchk_pulse_one", frame_err, 32'h0);
        send(8'hAA); send(8'h30); send(8'h00); send(8'h30);
        check("after_badchk_start", ch_start, 32'h8);
        ch_done = 4'b1000;
        tick();
        ch_done = '0;
        check("after_badchk_release", ch_grant, 32'h0);
`endif

        // Channel index 5 with NUM_CH=4 is rejected at the CODE byte
        send(8'hAA);
        send(8'h51);
        check("badch_ferr", frame_err, 32'h1);
        check("badch_busy", link_busy, 32'h0);
        send(8'h00);
        check("badch_grant", ch_grant,  32'h0);
        check("badch_ferr1", frame_err, 32'h0);

        // Auto-upload round-robin: requests on 1 and 3, pointer at 0
        ch_auto_req = 4'b1010;
        tick();
        check("auto_grant1", ch_grant, 32'h2);
        check("auto_nostart", ch_start, 32'h0);
        send(8'hAA);
        ch_done = 4'b0010;
        tick();
        ch_done = '0;
        check("auto_rel1", ch_grant, 32'h0);
        tick();
        check("auto_grant3", ch_grant, 32'h8);
        ch_done = 4'b1000;
        tick();
        ch_done = '0;
        check("auto_rel3", ch_grant, 32'h0);
        tick();
        check("auto_wrap1", ch_grant, 32'h2);
        ch_auto_req = '0;
        ch_done     = 4'b0010;
        tick();
        ch_done = '0;
        tick();
        check("auto_idle", link_busy, 32'h0);

        // Timeout on ch0 with transmitter idle
        send(8'hAA); send(8'h00); send(8'h00); send_chk(8'h00);
        check("to_grant", ch_grant, 32'h1);
        n = 0;
        for (int i = 1; i <= c_TIMEOUT + 100; i++) begin
            tick();
            if (timeout_err) begin
                n = i;
                break;
            end
        end
        check("to_latency", n, c_TIMEOUT);
        check("to_grant_drop", ch_grant, 32'h0);
        check("to_busy", link_busy, 32'h0);

        // Timeout with transmitter busy holds the grant until tx_idle
        send(8'hAA); send(8'h00); send(8'h00); send_chk(8'h00);
        tx_idle = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < c_TIMEOUT + 10; i++) begin
            tick();
            if (timeout_err) seen = 1'b1;
        end
        check("to_wait_tx_idle", seen, 32'h0);
        check("to_hold_grant", ch_grant, 32'h1);
        tx_idle = 1'b1;
        tick();
        check("to_late_err",   timeout_err, 32'h1);
        check("to_late_grant", ch_grant,    32'h0);

        // Inter-byte gap expiry
        send(8'hAA);
        send(8'h10);
        n = 0;
        for (int i = 1; i <= c_GAP + 20; i++) begin
            tick();
            if (frame_err) begin
                n = i;
                break;
            end
        end
        check("gap_latency", n, c_GAP);
        check("gap_busy", link_busy, 32'h0);

        // Reset in the middle of a payload
        send(8'hAA); send(8'h21); send(8'h02); send(8'h11);
        check("mid_pl_valid", ch_pl_valid, 32'h4);
        rst = 1'b1;
        tick();
        check("mrst_pl_valid", ch_pl_valid,  32'h0);
        check("mrst_pl_data",  ch_pl_data,   32'h0);
        check("mrst_code",     ch_ctrl_code, 32'h0);
        check("mrst_busy",     link_busy,    32'h0);
        check("mrst_grant",    ch_grant,     32'h0);
        rst = 1'b0;
        tick();

        send(8'hAA); send(8'h10); send(8'h00); send_chk(8'h10);
        check("recover_start", ch_start, 32'h2);
        ch_done = 4'b0010;
        tick();
        ch_done = '0;
        check("recover_release", ch_grant, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcu_link_dispatcher.md
Name: mcu_link_dispatcher

Overview:
- Parametrised MCU serial command dispatcher. It parses framed commands from the UART receiver and routes each one to one of NUM_CH service channels.
- It multiplexes the selected channel's transmit stream onto the single UART transmitter.
- It arbitrates channel-initiated auto-uploads (fault/trigger reports) round-robin.
- Sits between the uart232 core and the parameter/GPS/wave service blocks. It is the generalised replacement for the fixed four-way listen-plus-mux arrangement.

Parameters:
- NUM_CH, 4, number of service channels (1..16).
- HDR_BYTE, 8'hAA, frame start byte.
- TIMEOUT_CYCLES, 100_000_000, maximum clk cycles a channel may hold the link after dispatch.
- GAP_CYCLES, 1_000_000, maximum clk cycles between received bytes inside one frame.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous active-high reset.
- rx_data  in  8  UART received byte.
- rx_ok  in  1  one-cycle strobe; rx_data valid.
- tx_idle  in  1  UART transmitter idle.
- tx_data  out  8  byte to UART.
- start_tx  out  1  UART send strobe.
- ch_start  out  NUM_CH  one-hot, one-cycle command-accepted pulse.
- ch_ctrl_code  out  8  control code of current frame (held until next frame).
- ch_pl_data  out  8  payload byte.
- ch_pl_valid  out  NUM_CH  one-hot payload byte strobe to the addressed channel.
- ch_auto_req  in  NUM_CH  channel requests unsolicited upload (level).
- ch_grant  out  NUM_CH  one-hot; channel owns transmitter (module_run_flag equivalent).
- ch_tx_data  in  8*NUM_CH  per-channel tx byte; channel i at [8i+7:8i].
- ch_start_tx  in  NUM_CH  per-channel send strobe.
- ch_done  in  NUM_CH  channel finished; releases link.
- frame_err  out  1  one-cycle pulse: bad header sequence, bad channel, checksum or gap error.
- timeout_err  out  1  one-cycle pulse: channel exceeded TIMEOUT_CYCLES.
- link_busy  out  1  high in any state except IDLE.

Behaviour:
- Clocking and reset: single clock domain. Synchronous active-high reset. On reset all outputs are 0, the FSM enters IDLE, counters clear and the round-robin pointer is 0.
- Frame format: HDR_BYTE, CODE, LEN (0..255), LEN payload bytes, then CHK when MCU_FRAME_CHKSUM_EN is defined.
- Channel index: target channel = CODE[7:4]. If CODE[7:4] >= NUM_CH the frame is invalid.
- IDLE: rx_ok with rx_data == HDR_BYTE -> CODE. Otherwise, if any ch_auto_req is set -> AUTO (see arbitration). An rx header takes priority over an auto request in the same cycle.
- CODE: on rx_ok, latch ch_ctrl_code and check the channel index. Invalid -> frame_err, IDLE. Valid -> LEN.
- LEN: on rx_ok, latch the length. LEN == 0 -> CHK, or DISPATCH if checksum is disabled. Otherwise -> PAYLOAD.
- PAYLOAD: each rx_ok drives rx_data onto ch_pl_data and sets the target bit of ch_pl_valid on the same cycle as rx_ok registered, i.e. one cycle later. After LEN bytes -> CHK or DISPATCH.
- CHK: on rx_ok, compare against the 8-bit modulo-256 sum of CODE, LEN and all payload bytes. Match -> DISPATCH. Mismatch -> frame_err, IDLE. Channels must discard buffered payload on frame_err.
- Gap timeout: in CODE/LEN/PAYLOAD/CHK, the gap counter resets on each rx_ok. Reaching GAP_CYCLES -> frame_err, IDLE.
- DISPATCH:
  - Entry cycle: one-cycle ch_start pulse on the target channel; ch_grant target bit goes high and holds.
  - tx_data = ch_tx_data slice of the granted channel; start_tx = its ch_start_tx. Combinational mux, zero latency.
  - Bytes received during DISPATCH are ignored.
  - Exit on ch_done of the granted channel -> IDLE, grant drops the next cycle.
  - If the timeout counter reaches TIMEOUT_CYCLES first -> timeout_err, grant drops, IDLE. Grant drop waits for tx_idle so a byte in flight is never cut; the counter keeps saturating.
  - ch_done from a non-granted channel is ignored.
- AUTO: round-robin grant of the lowest requesting index at or above the pointer, wrapping. The pointer becomes granted+1, mod NUM_CH. Mux, done and timeout rules are identical to DISPATCH, but no ch_start pulse is issued. A header arriving during AUTO is dropped.
- Outside grant: tx_data = 0 and start_tx = 0. At most one ch_grant bit is set at any time.
- Mid-operation reset: returns to IDLE within the same cycle edge. Grants drop immediately and no pulse is emitted.

Optional Feature:
- MCU_FRAME_CHKSUM_EN defined: CHK byte is required and verified as described above.
- Undefined: no CHK state; the frame ends after the last payload byte (or after LEN when LEN == 0) and goes straight to DISPATCH. Checksum errors cannot occur.

Test Plan:
- NUM_CH=4, checksum on. Send AA 21 02 11 22 56 -> ch_pl_valid[2] pulses twice with 11 then 22, ch_start[2] pulses once, ch_grant=4'b0100. Channel sends 3 bytes then ch_done -> start_tx mirrors the 3 strobes, link returns to IDLE, link_busy=0.
- Send AA 21 01 33 00 (bad checksum) -> frame_err one pulse, ch_start stays 0, next valid frame is accepted normally.
- Send AA 51 00 with NUM_CH=4 -> frame_err after CODE byte, no grant.
- ch_auto_req=4'b1010 held with pointer 0 -> grant ch1; after done, grant ch3; after done, grant ch1 (wrap).
- Dispatch to ch0 with TIMEOUT_CYCLES=1000 and no ch_done -> timeout_err at cycle 1000 after grant, grant released, IDLE.
- Send AA 10 then no bytes for GAP_CYCLES -> frame_err, IDLE. Assert rst mid-PAYLOAD -> all outputs 0 the next cycle.
